// File: rtl/bus_arbiter4_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter4_pkg
// Shared definitions for the 4-way round-robin bus arbiter:
//   NREQ        number of requesters (fetch, load/store, DMA, debug)
//   SEL_W       width of the requester index / wordmux4 select
//   arb_state_t arbiter FSM states (ST_IDLE = no grant, ST_BUSY = one grant held)
//   onehot()    converts a requester index into a one-hot grant vector
// Optional feature macro used by the arbiter: ARB_TIMEOUT_EN
// ---------------------------------------------------------------------------
package bus_arbiter4_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/bus_arbiter4_mux.sv
// ---------------------------------------------------------------------------
// wordmux4
// Four-input word multiplexer steering the granted requester onto the bus.
// Ports:
//   i_d0..i_d3  in   WIDTH  requester data words
//   i_sel       in   2      select index
//   o_d         out  WIDTH  selected word
// ---------------------------------------------------------------------------
module wordmux4 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_d
);

    always_comb begin
        case (i_sel)
            2'd0:    o_d = i_d0;
            2'd1:    o_d = i_d1;
            2'd2:    o_d = i_d2;
            default: o_d = i_d3;
        endcase
    end

endmodule

// File: rtl/bus_arbiter4_pick.sv
// ---------------------------------------------------------------------------
// arb_pick4
// Combinational rotating-priority picker. The search starts at the requester
// after i_last and wraps, so i_last itself is examined last.
// Ports:
//   i_req    in   NREQ   candidate requests
//   i_last   in   SEL_W  index of the most recently granted requester
//   o_found  out  1      at least one candidate request is high
//   o_idx    out  SEL_W  index of the winning requester (i_last if none)
// ---------------------------------------------------------------------------
module arb_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [NREQ-1:0]  i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from the lowest priority (offset NREQ == i_last) up to the highest
    // (offset 1) so the last hit recorded is the highest-priority one.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_last;
        w_cand  = i_last;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = i_last + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// ---------------------------------------------------------------------------
// bus_arbiter4
// Round-robin arbiter sharing one WIDTH-bit word bus among 4 requesters.
// Grants are registered and one-hot; a holder keeps the bus while its request
// stays high and hands over at the same edge it releases (no idle gap).
// Optional macro ARB_TIMEOUT_EN: a holder is preempted after MAX_HOLD
// consecutive granted cycles when another request is pending.
// Ports:
//   i_clk       in   1      clock, rising edge
//   i_rst_n     in   1      asynchronous active-low reset
//   i_req       in   4      per-requester request, held for a transaction
//   i_data0..3  in   WIDTH  requester data words
//   o_gnt       out  4      registered one-hot grant (0 = bus idle)
//   o_sel       out  2      registered granted index (wordmux4 select)
//   o_valid     out  1      granted requester still requesting this cycle
//   o_data      out  WIDTH  data word of requester o_sel
//   o_preempt   out  1      one-cycle pulse when a grant moves by timeout
// ---------------------------------------------------------------------------
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NREQ-1:0]  i_req,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [WIDTH-1:0] i_data3,
    output logic [NREQ-1:0]  o_gnt,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_preempt
);

    arb_state_t       r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last;

    logic [NREQ-1:0]  w_pick_req;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic             w_busy;
    logic             w_held;
    logic             w_release;
    logic             w_timeout;
    logic             w_new;

    // The current holder is masked out so a timeout can only move the grant
    // to a different requester; in IDLE or on release its bit is 0 anyway.
    assign w_pick_req = i_req & ~r_gnt;

    arb_pick4 u_pick (
        .i_req   (w_pick_req),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_busy    = (r_state == ST_BUSY);
    assign w_held    = w_busy &  i_req[r_sel];
    assign w_release = w_busy & ~i_req[r_sel];

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic              r_preempt;
    logic [HOLD_W-1:0] r_hold;

    assign w_timeout = w_held & (r_hold == HOLD_LAST) & w_found;
    assign o_preempt = r_preempt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= w_timeout;
            if (w_new) begin
                r_hold <= '0;
            end else if (w_held && (r_hold != HOLD_LAST)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = |MAX_HOLD;
    assign w_timeout    = 1'b0;
    assign o_preempt    = 1'b0;
`endif

    assign w_new = w_found & (~w_busy | w_release | w_timeout);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_last  <= SEL_W'(NREQ - 1);
        end else begin
            if (w_new) begin
                r_state <= ST_BUSY;
                r_gnt   <= onehot(w_idx);
                r_sel   <= w_idx;
                r_last  <= w_idx;
            end else if (w_release) begin
                // Nobody else waiting: drop the bus; r_sel keeps its value.
                r_state <= ST_IDLE;
                r_gnt   <= '0;
            end
        end
    end

    assign o_gnt   = r_gnt;
    assign o_sel   = r_sel;
    assign o_valid = r_gnt[r_sel] & i_req[r_sel];

    wordmux4 #(.WIDTH(WIDTH)) u_mux (
        .i_d0  (i_data0),
        .i_d1  (i_data1),
        .i_d2  (i_data2),
        .i_d3  (i_data3),
        .i_sel (r_sel),
        .o_d   (o_data)
    );

endmodule

// File: tb/tb_bus_arbiter4.sv
module tb_bus_arbiter4;

    localparam int W        = 16;
    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic         i_clk;
    logic         i_rst_n;
    logic [3:0]   i_req;
    logic [W-1:0] i_data0, i_data1, i_data2, i_data3;
    logic [3:0]   o_gnt;
    logic [1:0]   o_sel;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         o_preempt;

    bus_arbiter4 #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_data0   (i_data0),
        .i_data1   (i_data1),
        .i_data2   (i_data2),
        .i_data3   (i_data3),
        .o_gnt     (o_gnt),
        .o_sel     (o_sel),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_preempt (o_preempt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [3:0]   gnt;
        logic [1:0]   sel;
        logic         valid;
        logic         pre;
        logic [W-1:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e_last;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: who owns the bus, who was served last, how long held.
    int   m_owner;
    int   m_last;
    int   m_hold;
    int   m_sel;
    bit   m_pre;
    logic [W-1:0] dat [4];
    bit   fix_d1 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] owner_mask();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_sel   = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_last  = w;
        m_sel   = w;
        m_hold  = 0;
    endtask

    // One clock edge of the arbiter's rules, applied to the sampled requests r.
    task automatic model_edge(input logic [3:0] r);
        int w;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_last);
            if (w >= 0) model_grant(w);
        end else if (!r[m_owner]) begin
            w = pick(r, m_last);
            if (w >= 0) model_grant(w);
            else m_owner = -1;
        end else if (TO && (m_hold == MAX_HOLD - 1) && ((r & ~owner_mask()) != 4'b0000)) begin
            w = pick(r & ~owner_mask(), m_last);
            model_grant(w);
            m_pre = 1'b1;
        end else if (m_hold < MAX_HOLD - 1) begin
            m_hold++;
        end
    endtask

    // Apply requests and data for the coming edge; record what the outputs
    // must show until that edge, then advance the model across it.
    task automatic drive(input logic [3:0] r);
        exp_t e;
        for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
        if (fix_d1) dat[1] = 16'hA5A5;
        i_req   = r;
        i_data0 = dat[0];
        i_data1 = dat[1];
        i_data2 = dat[2];
        i_data3 = dat[3];
        e.gnt   = owner_mask();
        e.sel   = 2'(m_sel);
        e.valid = (m_owner >= 0) && r[m_owner];
        e.pre   = m_pre;
        e.data  = dat[m_sel];
        q.push_back(e);
        e_last  = e;
        model_edge(r);
    endtask

    task automatic step(input logic [3:0] r);
        @(posedge i_clk);
        #2;
        drive(r);
    endtask

    // Reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset(input logic [3:0] rel_req, input bit precheck);
        @(negedge i_clk);
        #2;
        if (precheck) chk("pre_rst_gnt", {28'b0, o_gnt}, {28'b0, e_last.gnt});
        i_rst_n = 1'b0;
        #1;
        chk("rst_gnt",   {28'b0, o_gnt},     32'h0);
        chk("rst_valid", {31'b0, o_valid},   32'h0);
        chk("rst_sel",   {30'b0, o_sel},     32'h0);
        chk("rst_pre",   {31'b0, o_preempt}, 32'h0);
        repeat (2) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        model_reset();
        drive(rel_req);
    endtask

    // Monitor: every cycle with a pending expectation is compared away from
    // the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt",   {28'b0, o_gnt},     {28'b0, e.gnt});
                chk("sel",   {30'b0, o_sel},     {30'b0, e.sel});
                chk("valid", {31'b0, o_valid},   {31'b0, e.valid});
                chk("pre",   {31'b0, o_preempt}, {31'b0, e.pre});
                chk("data",  {16'b0, o_data},    {16'b0, e.data});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cur;
        i_rst_n = 1'b0;
        i_req   = 4'b1111;
        i_data0 = '0;
        i_data1 = '0;
        i_data2 = '0;
        i_data3 = '0;
        e_last  = '0;
        model_reset();

        // Reset with all requests high: req0 must win first.
        do_reset(4'b1111, 1'b0);

        // Every holder keeps the bus two cycles, releases, then re-requests.
        for (int r = 0; r < 6; r++) begin
            step(4'b1111);
            step(4'b1111);
            step(4'b1111 & ~owner_mask());
        end
        step(4'b0000);
        step(4'b0000);

        // Lone requester 2 for three granted cycles, then release to idle.
        do_reset(4'b0000, 1'b1);
        repeat (4) step(4'b0100);
        repeat (2) step(4'b0000);

        // Fixed data on requester 1 with data 0 changing every cycle.
        fix_d1 = 1'b1;
        repeat (5) step(4'b0010);
        repeat (2) step(4'b0000);
        fix_d1 = 1'b0;

        // Two requesters held continuously (timeout behaviour if enabled).
        repeat (40) step(4'b1001);
        repeat (2) step(4'b0000);

        // Reset while requester 1 holds the bus, then all request.
        repeat (3) step(4'b0010);
        do_reset(4'b1111, 1'b1);
        repeat (4) step(4'b1111);
        step(4'b0000);

        // Randomised traffic with occasional drops by waiting requesters.
        cur = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            logic [3:0] nxt;
            for (int b = 0; b < 4; b++) begin
                if (cur[b]) begin
                    if (m_owner == b) nxt[b] = ($urandom % 4) != 0;
                    else              nxt[b] = ($urandom % 16) != 0;
                end else begin
                    nxt[b] = ($urandom % 3) == 0;
                end
            end
            cur = nxt;
            if (n == 300) do_reset(cur, 1'b1);
            else          step(cur);
        end
        repeat (3) step(4'b0000);

        @(negedge i_clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
